// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-addressed single-port synchronous data memory for the MEM stage.
// Word and byte-lane stores, sign/zero-extended byte loads, registered read path.
// After reset a zeroing sweep clears the array; READY is held low until it completes.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned word accesses with ERR).
module data_mem_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_W,
    input  logic              MEM_R,
    input  logic              BYTE_EN,
    input  logic              SIGN_EXT,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA_in,
    output logic [DATA_W-1:0] DATA_out,
    output logic              RD_VALID,
    output logic              READY,
    output logic              ERR
);

    localparam int BPW = DATA_W / 8;
    localparam int LB  = $clog2(BPW);
    localparam int IB  = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q;
    logic [IB-1:0]     sweep_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IB-1:0]     idx;
    logic [LB-1:0]     lane;
    logic              oor;
    logic              mis;
    logic              fault;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] rd_word;
    logic [7:0]        rd_byte;
    logic [DATA_W-1:0] ld_val;

    assign idx    = ADDR[IB+LB-1:LB];
    assign lane   = ADDR[LB-1:0];
    assign oor    = (ADDR >> (IB + LB)) != '0;
    assign mis    = !BYTE_EN && (lane != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault  = oor | mis;
`else
    assign fault  = oor;
`endif
    assign accept = (state_q == RUN) && !rst;
    assign wr_en  = accept && MEM_W && !fault;

    assign cur_word = mem[idx];

    // Merge store data into the addressed word: full word, or only the addressed lane.
    always_comb begin
        word_d = cur_word;
        for (int unsigned i = 0; i < BPW; i++) begin
            if (!BYTE_EN)
                word_d[8*i +: 8] = DATA_in[8*i +: 8];
            else if (lane == LB'(i))
                word_d[8*i +: 8] = DATA_in[7:0];
        end
    end

    // Write-first: a load in the same cycle as a store sees the merged word.
    assign rd_word = wr_en ? word_d : cur_word;
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];

    // Load value: full word or extended byte; faulting loads return zero.
    always_comb begin
        ld_val = rd_word;
        if (BYTE_EN)
            ld_val = {{(DATA_W-8){SIGN_EXT & rd_byte[7]}}, rd_byte};
        if (fault)
            ld_val = '0;
    end

    // Array writes: zeroing sweep during INIT, accepted stores during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT)
                mem[sweep_q] <= '0;
            else if (wr_en)
                mem[idx] <= word_d;
        end
    end

    // Sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    rd_valid_q <= 1'b0;
                    err_q      <= 1'b0;
                    sweep_q    <= sweep_q + 1'b1;
                    if (sweep_q == IB'(DEPTH - 1))
                        state_q <= RUN;
                end
                RUN: begin
                    rd_valid_q <= MEM_R;
                    err_q      <= (MEM_W | MEM_R) & fault;
                    if (MEM_R)
                        data_out_q <= ld_val;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign DATA_out = data_out_q;
    assign RD_VALID = rd_valid_q;
    assign READY    = (state_q == RUN);
    assign ERR      = err_q;

endmodule
